control_fsm: RTL and testbench

Multi-cycle control unit for the 10-bit datapath. Consumes the latched instruction word, sequences each instruction over 2–4 clock cycles, and drives the register file's write/read enables and addresses, the ALU operand/result latches, the external-data bus enable and the Done strobe. It sits directly upstream of `registerFile` and the ALU, and downstream of the instruction register.

---
 rtl/ctrl_pkg.sv | 46 ++++
 rtl/opcode_decoder.sv | 31 +++
 rtl/control_fsm.sv | 138 +++++++++++++
 tb/tb_control_fsm.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared types and constants for the 10-bit datapath control unit.
// Optional feature macro used by the top: CTRL_ILLEGAL_EN.
package ctrl_pkg;

   typedef enum logic [3:0] {
      OP_LOAD = 4'd0,
      OP_COPY = 4'd1,
      OP_ADD  = 4'd2,
      OP_SUB  = 4'd3,
      OP_INV  = 4'd4,
      OP_FLP  = 4'd5,
      OP_AND  = 4'd6,
      OP_OR   = 4'd7,
      OP_XOR  = 4'd8
   } opcode_t;

   typedef enum logic [1:0] {
      T0 = 2'd0,
      T1 = 2'd1,
      T2 = 2'd2,
      T3 = 2'd3
   } state_t;

   // ALU select codes equal the opcode so ALUcont can be driven straight from IR.
   localparam logic [3:0] ALU_ADD = 4'd2;
   localparam logic [3:0] ALU_SUB = 4'd3;
   localparam logic [3:0] ALU_INV = 4'd4;
   localparam logic [3:0] ALU_FLP = 4'd5;
   localparam logic [3:0] ALU_AND = 4'd6;
   localparam logic [3:0] ALU_OR  = 4'd7;
   localparam logic [3:0] ALU_XOR = 4'd8;

   localparam int IR_W   = 10;
   localparam int OP_MSB = 9;
   localparam int OP_LSB = 6;
   localparam int RX_MSB = 5;
   localparam int RX_LSB = 4;
   localparam int RY_MSB = 3;
   localparam int RY_LSB = 2;

   function automatic logic is_binary_op(input logic [3:0] op);
      return (op == ALU_ADD) || (op == ALU_SUB) || (op == ALU_AND) ||
             (op == ALU_OR)  || (op == ALU_XOR);
   endfunction

endpackage

// File: rtl/opcode_decoder.sv
// Combinational instruction decode: opcode class flags plus register fields.
module opcode_decoder
   import ctrl_pkg::*;
(
   input  logic [IR_W-1:0] i_ir,
   output logic [3:0]      o_op,
   output logic            o_is_load,
   output logic            o_is_copy,
   output logic            o_is_binary,
   output logic            o_is_unary,
   output logic            o_is_illegal,
   output logic [1:0]      o_rx,
   output logic [1:0]      o_ry
);

   logic [3:0] w_op;
   logic       w_ir_unused;

   assign w_op        = i_ir[OP_MSB:OP_LSB];
   assign w_ir_unused = ^i_ir[1:0];

   assign o_op         = w_op;
   assign o_is_load    = (w_op == OP_LOAD);
   assign o_is_copy    = (w_op == OP_COPY);
   assign o_is_binary  = is_binary_op(w_op);
   assign o_is_unary   = (w_op == ALU_INV) || (w_op == ALU_FLP);
   assign o_is_illegal = (w_op > OP_XOR);
   assign o_rx         = i_ir[RX_MSB:RX_LSB];
   assign o_ry         = i_ir[RY_MSB:RY_LSB];

endmodule

// File: rtl/control_fsm.sv
// Multi-cycle T0..T3 sequencer for the register file / ALU datapath.
// Optional CTRL_ILLEGAL_EN adds a sticky Illegal flag for undefined opcodes.
module control_fsm
   import ctrl_pkg::*;
(
   input  logic            CLKb,
   input  logic            RST,
   input  logic            Exec,
   input  logic [IR_W-1:0] IR,
   output logic            IRin,
   output logic            ENW,
   output logic [1:0]      WRA,
   output logic            ENR0,
   output logic            ENR1,
   output logic [1:0]      RDA0,
   output logic [1:0]      RDA1,
   output logic            Ain,
   output logic            Gin,
   output logic            Gout,
   output logic [3:0]      ALUcont,
   output logic            Extrn,
   output logic            Done,
`ifdef CTRL_ILLEGAL_EN
   output logic            Illegal,
`endif
   output state_t          o_dbg_state
);

   state_t     r_state;
   state_t     w_next;
   logic [3:0] w_op;
   logic       w_is_load;
   logic       w_is_copy;
   logic       w_is_binary;
   logic       w_is_unary;
   logic       w_is_illegal;
   logic [1:0] w_rx;
   logic [1:0] w_ry;

   opcode_decoder u_dec (
      .i_ir         (IR),
      .o_op         (w_op),
      .o_is_load    (w_is_load),
      .o_is_copy    (w_is_copy),
      .o_is_binary  (w_is_binary),
      .o_is_unary   (w_is_unary),
      .o_is_illegal (w_is_illegal),
      .o_rx         (w_rx),
      .o_ry         (w_ry)
   );

   always_ff @(posedge CLKb) begin
      if (RST) r_state <= T0;
      else     r_state <= w_next;
   end

   // Outputs are forced low while RST is high so an aborted instruction never writes.
   always_comb begin
      w_next  = r_state;
      IRin    = 1'b0;
      ENW     = 1'b0;
      WRA     = 2'd0;
      ENR0    = 1'b0;
      ENR1    = 1'b0;
      RDA0    = 2'd0;
      RDA1    = 2'd0;
      Ain     = 1'b0;
      Gin     = 1'b0;
      Gout    = 1'b0;
      ALUcont = 4'd0;
      Extrn   = 1'b0;
      Done    = 1'b0;
      if (!RST) begin
         case (r_state)
            T0: begin
               if (Exec) begin
                  IRin   = 1'b1;
                  w_next = T1;
               end
            end
            T1: begin
               w_next = T0;
               if (w_is_load) begin
                  Extrn = 1'b1;
                  ENW   = 1'b1;
                  WRA   = w_rx;
                  Done  = 1'b1;
               end else if (w_is_copy) begin
                  ENR0 = 1'b1;
                  RDA0 = w_ry;
                  ENW  = 1'b1;
                  WRA  = w_rx;
                  Done = 1'b1;
               end else if (w_is_binary || w_is_unary) begin
                  ENR0   = 1'b1;
                  RDA0   = w_rx;
                  Ain    = 1'b1;
                  w_next = T2;
               end else if (w_is_illegal) begin
                  Done = 1'b1;
               end
            end
            T2: begin
               ALUcont = w_op;
               Gin     = 1'b1;
               if (w_is_binary) begin
                  ENR1 = 1'b1;
                  RDA1 = w_ry;
               end
               w_next = T3;
            end
            T3: begin
               Gout   = 1'b1;
               ENW    = 1'b1;
               WRA    = w_rx;
               Done   = 1'b1;
               w_next = T0;
            end
            default: w_next = T0;
         endcase
      end
   end

`ifdef CTRL_ILLEGAL_EN
   logic r_illegal;

   always_ff @(posedge CLKb) begin
      if (RST)                         r_illegal <= 1'b0;
      else if (r_state == T0 && Exec)  r_illegal <= 1'b0;
      else if (r_state == T1 && w_is_illegal) r_illegal <= 1'b1;
   end

   assign Illegal = r_illegal;
`endif

   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_control_fsm.sv
// Bench for control_fsm: per-cycle expected-output schedule, bench register file and ALU.
module tb_control_fsm;

  logic       CLKb = 1'b0;
  logic       RST  = 1'b1;
  logic       Exec = 1'b1;
  logic [9:0] IR   = 10'd0;
  logic       IRin, ENW, ENR0, ENR1, Ain, Gin, Gout, Extrn, Done;
  logic [1:0] WRA, RDA0, RDA1;
  logic [3:0] ALUcont;
  logic [1:0] dbg_state;
`ifdef CTRL_ILLEGAL_EN
  logic       Illegal;
`endif

  int checks = 0;
  int errors = 0;

  always #5 CLKb = ~CLKb;

  control_fsm dut (
    .CLKb(CLKb), .RST(RST), .Exec(Exec), .IR(IR),
    .IRin(IRin), .ENW(ENW), .WRA(WRA), .ENR0(ENR0), .ENR1(ENR1),
    .RDA0(RDA0), .RDA1(RDA1), .Ain(Ain), .Gin(Gin), .Gout(Gout),
    .ALUcont(ALUcont), .Extrn(Extrn), .Done(Done),
`ifdef CTRL_ILLEGAL_EN
    .Illegal(Illegal),
`endif
    .o_dbg_state(dbg_state)
  );

  typedef struct packed {
    logic       irin;
    logic       enw;
    logic [1:0] wra;
    logic       enr0;
    logic [1:0] rda0;
    logic       enr1;
    logic [1:0] rda1;
    logic       ain;
    logic       gin;
    logic       gout;
    logic [3:0] alu;
    logic       extrn;
    logic       done;
  } outs_t;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [9:0] alu_f(input logic [3:0] op, input logic [9:0] a, input logic [9:0] b);
    logic [9:0] r;
    r = 10'd0;
    case (op)
      4'd2: r = a + b;
      4'd3: r = a - b;
      4'd4: r = ~a;
      4'd5: for (int i = 0; i < 10; i++) r[i] = a[9-i];
      4'd6: r = a & b;
      4'd7: r = a | b;
      4'd8: r = a ^ b;
      default: r = 10'd0;
    endcase
    return r;
  endfunction

  // Bench-side datapath driven by the DUT control outputs.
  logic [9:0] ext_data = 10'd0;
  logic [9:0] bench_rf [4] = '{default: 10'd0};
  logic [9:0] a_reg = 10'd0;
  logic [9:0] g_reg = 10'd0;
  logic [9:0] bus;

  always_comb begin
    bus = 10'd0;
    if (Extrn)     bus = ext_data;
    else if (Gout) bus = g_reg;
    else if (ENR0) bus = bench_rf[RDA0];
  end

  always @(posedge CLKb) begin
    if (Ain) a_reg <= bench_rf[RDA0];
    if (Gin) g_reg <= alu_f(ALUcont, a_reg, ENR1 ? bench_rf[RDA1] : 10'd0);
    if (ENW) bench_rf[WRA] <= bus;
  end

  // Instruction-level model: expected output vector per cycle, architectural register file.
  outs_t      exp_q[$];
  logic [9:0] model_rf [4] = '{default: 10'd0};
  logic       pend_valid = 1'b0;
  logic       pend_wr    = 1'b0;
  logic       pend_load  = 1'b0;
  logic [1:0] pend_rx    = 2'd0;
  logic [9:0] pend_val   = 10'd0;
  logic       model_illegal = 1'b0;
  logic       pend_illegal  = 1'b0;
  outs_t      act_v, exp_v, e;
  logic [3:0] m_op;
  logic [1:0] m_rx, m_ry;

  always @(negedge CLKb) begin
    act_v = {IRin, ENW, WRA, ENR0, RDA0, ENR1, RDA1, Ain, Gin, Gout, ALUcont, Extrn, Done};
    for (int i = 0; i < 4; i++) check($sformatf("rf%0d", i), bench_rf[i], model_rf[i]);
`ifdef CTRL_ILLEGAL_EN
    check("illegal", Illegal, model_illegal);
`endif
    exp_v = '0;
    if (RST) begin
      exp_q.delete();
      pend_valid    = 1'b0;
      model_illegal = 1'b0;
    end else if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      if (exp_v.done && pend_valid) begin
        if (pend_wr) model_rf[pend_rx] = pend_load ? ext_data : pend_val;
        if (pend_illegal) model_illegal = 1'b1;
        pend_valid = 1'b0;
      end
    end else if (Exec) begin
      exp_v.irin    = 1'b1;
      model_illegal = 1'b0;
      m_op = IR[9:6]; m_rx = IR[5:4]; m_ry = IR[3:2];
      pend_valid = 1'b1; pend_wr = 1'b1; pend_load = 1'b0; pend_illegal = 1'b0;
      pend_rx = m_rx; pend_val = 10'd0;
      e = '0;
      if (m_op == 4'd0) begin
        e.extrn = 1'b1; e.enw = 1'b1; e.wra = m_rx; e.done = 1'b1;
        exp_q.push_back(e);
        pend_load = 1'b1;
      end else if (m_op == 4'd1) begin
        e.enr0 = 1'b1; e.rda0 = m_ry; e.enw = 1'b1; e.wra = m_rx; e.done = 1'b1;
        exp_q.push_back(e);
        pend_val = model_rf[m_ry];
      end else if (m_op <= 4'd8) begin
        e.enr0 = 1'b1; e.rda0 = m_rx; e.ain = 1'b1;
        exp_q.push_back(e);
        e = '0;
        e.alu = m_op; e.gin = 1'b1;
        if (m_op != 4'd4 && m_op != 4'd5) begin
          e.enr1 = 1'b1; e.rda1 = m_ry;
        end
        exp_q.push_back(e);
        e = '0;
        e.gout = 1'b1; e.enw = 1'b1; e.wra = m_rx; e.done = 1'b1;
        exp_q.push_back(e);
        pend_val = alu_f(m_op, model_rf[m_rx], model_rf[m_ry]);
      end else begin
        e.done = 1'b1;
        exp_q.push_back(e);
        pend_wr = 1'b0; pend_illegal = 1'b1;
      end
    end
    check("outs", act_v, exp_v);
  end

  task automatic step();
    @(posedge CLKb);
    #1;
  endtask

  task automatic issue(input string nm, input logic [9:0] ir, input int exp_lat);
    int lat;
    lat  = -1;
    IR   = ir;
    Exec = 1'b1;
    @(negedge CLKb);
    check({nm, "_irin"}, IRin, 1'b1);
    step();
    Exec = 1'b0;
    for (int c = 1; c <= 8 && lat < 0; c++) begin
      @(negedge CLKb);
      if (Done) lat = c;
      step();
    end
    check({nm, "_latency"}, lat, exp_lat);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] r_op;
    repeat (2) begin
      @(negedge CLKb);
      check("rst_irin", IRin, 1'b0);
      check("rst_done", Done, 1'b0);
      step();
    end
    RST  = 1'b0;
    Exec = 1'b0;
    step();

    ext_data = 10'h005; issue("load_r1", 10'h010, 1);
    ext_data = 10'h007; issue("load_r2", 10'h020, 1);
    ext_data = 10'h2A5; issue("load_r3", 10'h030, 1);
    check("r3_loaded", bench_rf[3], 10'h2A5);
    issue("add_r1_r2", 10'h098, 3);
    check("add_result", bench_rf[1], 10'h00C);
    ext_data = 10'h00F; issue("load_r2b", 10'h020, 1);
    issue("inv_r2", 10'h120, 3);
    check("inv_result", bench_rf[2], 10'h3F0);
    issue("copy_r0_r3", 10'h04C, 1);
    check("copy_result", bench_rf[0], 10'h2A5);
    issue("undef_op15", 10'h3C0, 1);
    check("undef_no_write", bench_rf[0], 10'h2A5);

    // Exec during T2 is dropped; a second ADD is reset in its T2.
    IR = 10'h098; Exec = 1'b1; step();
    Exec = 1'b0; step();
    Exec = 1'b1; step();
    Exec = 1'b0;
    @(negedge CLKb); check("abort_first_done", Done, 1'b1);
    step();
    @(negedge CLKb); check("exec_not_queued", IRin, 1'b0);
    step();
    Exec = 1'b1; step();
    Exec = 1'b0; step();
    RST = 1'b1;
    @(negedge CLKb);
    check("abort_enw", ENW, 1'b0);
    check("abort_done", Done, 1'b0);
    step();
    RST = 1'b0;
    repeat (3) begin
      @(negedge CLKb);
      check("post_abort_done", Done, 1'b0);
      check("post_abort_enw", ENW, 1'b0);
      step();
    end
    check("abort_r1", bench_rf[1], 10'h3FC);

    for (int n = 0; n < 2000; n++) begin
      ext_data = 10'($urandom);
      RST  = ($urandom_range(0, 63) == 0);
      Exec = $urandom_range(0, 1);
      if (exp_q.size() == 0) begin
        r_op = 4'($urandom_range(0, 15));
        if ($urandom_range(0, 9) < 8) r_op = 4'($urandom_range(0, 8));
        IR = {r_op, 6'($urandom)};
      end
      step();
    end
    RST = 1'b0; Exec = 1'b0;
    repeat (5) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
